// File: rtl/md_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_pkg : op encoding, FSM states and decode helpers for the HI/LO unit    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_FIX  = 2'd3;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Even op codes are the signed variants.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_div_core : iterative restoring divider on unsigned magnitudes          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module md_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic               r_done;
    logic [2*WIDTH-1:0] w_first;
    logic [2*WIDTH-1:0] w_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor whenever it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {rem, quo[WIDTH-1]};
        diff = sh - {1'b0, dvs};
        if (sh >= {1'b0, dvs})
            return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        else
            return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    // The load edge already performs the first step, so W steps finish W-1
    // edges after start.
    assign w_first = div_step('0, dividend, divisor);
    assign w_next  = div_step(r_rem, r_quo, r_dvs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                {r_rem, r_quo} <= w_first;
                r_dvs          <= divisor;
                r_cnt          <= CW'(WIDTH - 1);
                r_run          <= 1'b1;
            end else if (r_run) begin
                {r_rem, r_quo} <= w_next;
                r_cnt          <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: rtl/md_unit_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_unit_iter : W-bit HI/LO multiply / MAC / iterative divide unit         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module md_unit_iter
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             WrHI,
    input  logic             WrLO,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_div_start;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_done;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic               w_div0;
    logic               w_q_neg;
    logic               w_r_neg;
    logic [WIDTH-1:0]   w_fix_quo;
    logic [WIDTH-1:0]   w_fix_rem;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign w_accept    = (r_state == ST_IDLE) && Start;
    assign w_div_start = w_accept && is_div(Op);

    md_div_core #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (reset),
        .start    (w_div_start),
        .dividend (mag(D1, is_signed(Op))),
        .divisor  (mag(D2, is_signed(Op))),
        .quotient (w_quo),
        .remainder(w_rem),
        .done     (w_div_done)
    );

    // Sign/zero extension to 2W makes a single modulo-2^(2W) multiplier
    // serve both signed and unsigned variants.
    assign w_ext_a = is_signed(r_op) ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b = is_signed(r_op) ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    always_comb begin
        w_mul_res = w_prod;
        if (is_acc(r_op))
            w_mul_res = is_sub(r_op) ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
    end

    assign w_div0    = (r_b == '0);
    assign w_q_neg   = is_signed(r_op) & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg   = is_signed(r_op) & r_a[WIDTH-1];
    assign w_fix_quo = w_div0 ? '1  : (w_q_neg ? -w_quo : w_quo);
    assign w_fix_rem = w_div0 ? r_a : (w_r_neg ? -w_rem : w_rem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_MULT;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= D1;
                        r_b     <= D2;
                        r_op    <= Op;
                        r_cnt   <= CW'(1);
                        r_state <= is_div(Op) ? ST_DIV : ST_MUL;
                    end else begin
                        if (WrHI) r_hi <= WData;
                        if (WrLO) r_lo <= WData;
                    end
                end
                ST_MUL: begin
                    if (r_cnt == CW'(MUL_CYCLES)) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (w_div_done) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi    <= w_fix_rem;
                    r_lo    <= w_fix_quo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (r_state != ST_IDLE);
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_md_unit_iter : directed + random checks of md_unit_iter vs a model     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_md_unit_iter;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam logic [2:0] K_MULT = 3'd0, K_MULTU = 3'd1, K_DIV = 3'd2, K_DIVU = 3'd3;
    localparam logic [2:0] K_MADD = 3'd4, K_MADDU = 3'd5, K_MSUB = 3'd6, K_MSUBU = 3'd7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  D1 = '0, D2 = '0, WData = '0;
    logic          Start = 1'b0, WrHI = 1'b0, WrLO = 1'b0;
    logic [2:0]    Op = '0;
    logic          Busy, Done;
    logic [W-1:0]  HI, LO;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    md_unit_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .D1(D1), .D2(D2), .Start(Start), .Op(Op),
        .WrHI(WrHI), .WrLO(WrLO), .WData(WData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference: {HI,LO} as one 64-bit value, plus a count of busy cycles left.
    logic [63:0] m_acc;
    int          m_rem;
    logic        m_done;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b;

    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] ps, pu;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            K_MULT:  return ps;
            K_MULTU: return pu;
            K_MADD:  return acc + ps;
            K_MADDU: return acc + pu;
            K_MSUB:  return acc - ps;
            K_MSUBU: return acc - pu;
            K_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc  <= '0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 1) begin
                m_rem <= m_rem - 1;
            end else if (m_rem == 1) begin
                m_rem  <= 0;
                m_acc  <= model_res(m_op, m_a, m_b, m_acc);
                m_done <= 1'b1;
            end else if (Start) begin
                m_op  <= Op;
                m_a   <= D1;
                m_b   <= D2;
                m_rem <= (Op == K_DIV || Op == K_DIVU) ? W + 1 : MC;
            end else begin
                if (WrHI) m_acc[63:32] <= WData;
                if (WrLO) m_acc[31:0]  <= WData;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({Busy, Done, HI, LO} !== {(m_rem != 0), m_done, m_acc}) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: got busy=%b done=%b hi=%h lo=%h, want busy=%b done=%b hi=%h lo=%h",
                         $time, Busy, Done, HI, LO, (m_rem != 0), m_done, m_acc[63:32], m_acc[31:0]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input bit align, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_len,
                          input bit check_vals, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int interfere_at, input bit wr_with_start, input bit junk);
        int len;
        logic [31:0] r;
        if (align) begin @(negedge clk); #1; end
        Start = 1'b1; Op = op; D1 = a; D2 = b;
        if (wr_with_start) begin WrHI = 1'b1; WrLO = 1'b1; WData = 32'd77; end
        @(negedge clk); #1;
        Start = 1'b0; WrHI = 1'b0; WrLO = 1'b0;
        len = 0;
        while (Busy === 1'b1 && len < 100) begin
            len++;
            if (junk) begin
                r = $urandom;
                Start = (r[1:0] == 2'd0); Op = r[4:2]; WrHI = r[5]; WrLO = r[6];
                D1 = $urandom; D2 = $urandom; WData = $urandom;
            end else if (len == interfere_at) begin
                Start = 1'b1; Op = K_MULT; D1 = 32'd7; D2 = 32'd9; WrHI = 1'b1; WData = 32'd55;
            end else begin
                Start = 1'b0; WrHI = 1'b0; WrLO = 1'b0;
            end
            @(negedge clk); #1;
        end
        Start = 1'b0; WrHI = 1'b0; WrLO = 1'b0;
        check({name, " busy_len"}, 64'(len), 64'(exp_len));
        check({name, " done"}, 64'(Done), 64'd1);
        if (check_vals) begin
            check({name, " hi"}, 64'(HI), 64'(exp_hi));
            check({name, " lo"}, 64'(LO), 64'(exp_lo));
        end
    endtask

    function automatic logic [31:0] pick(input logic [2:0] sel);
        case (sel)
            3'd0: return 32'd0;
            3'd1: return 32'd1;
            3'd2: return 32'hFFFFFFFF;
            3'd3: return 32'h80000000;
            3'd4: return 32'h7FFFFFFF;
            3'd5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int done_seen;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset hi", 64'(HI), 64'd0);
        check("reset lo", 64'(LO), 64'd0);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        #1 reset = 1'b0;

        run_op("div85",   1, K_DIV,  32'd85, 32'd2, 33, 1, 32'd1, 32'd42, 0, 0, 0);
        run_op("divu85",  1, K_DIVU, 32'd85, 32'd2, 33, 1, 32'd1, 32'd42, 0, 0, 0);
        run_op("div_m7",  1, K_DIV,  32'hFFFFFFF9, 32'd2, 33, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
        run_op("div_min", 1, K_DIV,  32'h80000000, 32'hFFFFFFFF, 33, 1, 32'd0, 32'h80000000, 0, 0, 0);
        run_op("divu_z",  1, K_DIVU, 32'd5, 32'd0, 33, 1, 32'd5, 32'hFFFFFFFF, 0, 0, 0);
        run_op("div_z",   1, K_DIV,  32'hFFFFFFFB, 32'd0, 33, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 0, 0);
        run_op("div_n7",  1, K_DIV,  32'd100, 32'hFFFFFFF9, 33, 1, 32'd2, 32'hFFFFFFF2, 0, 0, 0);
        run_op("mult",    1, K_MULT, 32'hFFFFFFFF, 32'd2, 5, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0);
        run_op("multu",   1, K_MULTU, 32'hFFFFFFFF, 32'd2, 5, 1, 32'd1, 32'hFFFFFFFE, 0, 0, 0);

        @(negedge clk); #1;
        WrHI = 1'b1; WrLO = 1'b1; WData = 32'd10;
        @(negedge clk); #1;
        WrHI = 1'b0; WrLO = 1'b0;
        check("wr hi", 64'(HI), 64'd10);
        check("wr lo", 64'(LO), 64'd10);

        run_op("maddu",   1, K_MADDU, 32'd3, 32'd4, 5, 1, 32'd10, 32'd22, 0, 0, 0);
        run_op("msubu_b2b", 0, K_MSUBU, 32'd1, 32'd23, 5, 1, 32'd9, 32'hFFFFFFFF, 0, 0, 0);
        run_op("madd",    1, K_MADD, 32'hFFFFFFFF, 32'd3, 5, 1, 32'd9, 32'hFFFFFFFC, 0, 0, 0);
        run_op("msub",    0, K_MSUB, 32'hFFFFFFFE, 32'hFFFFFFFD, 5, 1, 32'd9, 32'hFFFFFFF6, 0, 0, 0);
        run_op("maddu_wrap", 1, K_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1, 32'd7, 32'hFFFFFFF7, 0, 0, 0);
        run_op("start_wins", 1, K_MULTU, 32'd3, 32'd5, 5, 1, 32'd0, 32'd15, 0, 1, 0);
        run_op("div_ignore", 1, K_DIV, 32'd100, 32'd7, 33, 1, 32'd2, 32'd14, 3, 0, 0);

        // Async reset in the middle of a divide.
        @(negedge clk); #1;
        Start = 1'b1; Op = K_DIV; D1 = 32'd1000; D2 = 32'd3;
        @(negedge clk); #1;
        Start = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midop_rst hi", 64'(HI), 64'd0);
        check("midop_rst lo", 64'(LO), 64'd0);
        check("midop_rst busy", 64'(Busy), 64'd0);
        check("midop_rst done", 64'(Done), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done === 1'b1) done_seen++;
        end
        check("midop_rst no_done", 64'(done_seen), 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            logic [2:0]  op;
            r  = $urandom;
            op = r[9:7];
            if (r[3:0] == 4'd0) begin
                @(negedge clk); #1;
                WrHI = r[4]; WrLO = r[5]; WData = $urandom;
                @(negedge clk); #1;
                WrHI = 1'b0; WrLO = 1'b0;
            end
            run_op("rand", r[6], op, pick(r[12:10]), pick(r[15:13]),
                   (op == K_DIV || op == K_DIVU) ? 33 : 5, 0, 32'd0, 32'd0, 0, 0, r[16]);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
- Parametrised successor to the pipeline's multiply/divide unit: a W-bit HI/LO unit.
- Operations: signed/unsigned multiply, multiply-accumulate and multiply-subtract into {HI,LO}, iterative restoring divide, and direct HI/LO writes (mthi/mtlo).
- Sits beside the EX-stage ALU. The pipeline stalls mult/div/mfhi/mflo while Busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width (W); must be ≥ 4.
- MUL_CYCLES, 5, Busy duration for all multiply-class ops; must be ≥ 1.
- DIV_CYCLES, derived = WIDTH+1; one quotient bit per cycle plus one sign-fix cycle. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- D1  in  W  operand A: multiplicand / dividend; sampled only on accepted Start
- D2  in  W  operand B: multiplier / divisor; sampled only on accepted Start
- Start  in  1  launch the op in Op (single-cycle pulse)
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- WrHI  in  1  write WData to HI
- WrLO  in  1  write WData to LO
- WData  in  W  data for WrHI/WrLO
- Busy  out  1  op in progress
- Done  out  1  one-cycle pulse: HI/LO just committed by an op
- HI  out  W  high half / remainder
- LO  out  W  low half / quotient

Behaviour:
- Reset (async, any time, including mid-op): HI=0, LO=0, Busy=0, Done=0, FSM→IDLE. The in-flight op is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- Acceptance: Start is accepted only when Busy=0. D1, D2 and Op are latched on edge k.
- Timing from accepted edge k:
  - Busy=1 from edge k through edge k+N-1.
  - HI/LO and Done=1 are updated at edge k+N; Busy=0 at that same edge.
  - N = MUL_CYCLES for ops 0,1,4,5,6,7; N = WIDTH+1 for ops 2,3.
  - Back-to-back: a new Start on the cycle after Busy falls is accepted.
- Ignored inputs: Start while Busy=1 is ignored (no queueing). WrHI/WrLO while Busy=1 are ignored.
- Priority in IDLE when Start and WrHI/WrLO arrive together: Start wins and the writes are dropped.
- HI/LO writes: WrHI and WrLO may be asserted together. Each updates its register at the next edge with no Done pulse.
- Multiply: 2W-bit product P = D1*D2, signed for ops 0,4,6 and unsigned for 1,5,7. P is computed in the first MUL cycle, then a counter runs to N.
  - MULT/MULTU: {HI,LO}=P.
  - MADD*: {HI,LO}+=P.
  - MSUB*: {HI,LO}-=P.
  - Accumulate arithmetic is modulo 2^(2W). The accumulate base is {HI,LO} as they stand at commit time.
- Divide (DIV state): restoring algorithm on magnitudes, W iterations.
  - FIX state applies signs: quotient truncates toward zero; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - Divisor 0 (signed or unsigned): LO = all ones, HI = D1 unchanged. Full latency still applies.
  - Signed MIN/-1: LO = MIN, HI = 0.
- Outputs: HI/LO are always register outputs. They hold their old values while Busy.

Decomposition:
- Package md_pkg holds:
  - op encoding constants (OP_MULT..OP_MSUBU)
  - FSM state typedef
  - helper functions is_div(op), is_signed(op)
- Sub-module md_div_core holds the iterative magnitude divider:
  - inputs: start, dividend magnitude, divisor magnitude
  - outputs: quotient, remainder, done after W cycles
  - parameter: WIDTH
- md_unit_iter keeps the control FSM, multiplier, accumulate and sign fix-up.

Test Plan:
- DIV D1=85, D2=2 at edge k → Busy high 33 cycles, at k+33 LO=42, HI=1, Done=1 for one cycle. Repeat with DIVU: same result.
- DIV D1=-7 (0xFFFFFFF9), D2=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- MULT 0xFFFFFFFF × 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after 5 cycles. MULTU same operands → HI=1, LO=0xFFFFFFFE.
- WrHI=WrLO=1, WData=10 → HI=LO=10. Then MADDU 3×4 → LO=22, HI=10. Then MSUBU 1×23 → HI=9, LO=0xFFFFFFFF.
- Start a DIV, pulse Start with MULT and WrHI at cycle 3 → both ignored, DIV result unchanged. Assert reset at cycle 10 → HI=LO=0 and Busy=0 immediately (async), no Done.
- Re-run the directed and 10k random ops at WIDTH=16, MUL_CYCLES=1 against a reference model. Check Busy length = N exactly and back-to-back Start acceptance on the cycle Busy falls.
